// File: rtl/td4_datapath_pkg.sv
// td4_datapath_pkg: shared source-select codes, load bit indices and default width for TD4
package td4_datapath_pkg;
    localparam int TD4_WIDTH = 4;
    localparam logic [1:0] SEL_A    = 2'd0;
    localparam logic [1:0] SEL_B    = 2'd1;
    localparam logic [1:0] SEL_IN   = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;
    localparam int LD_A   = 0;
    localparam int LD_B   = 1;
    localparam int LD_OUT = 2;
    localparam int LD_PC  = 3;
endpackage

// File: rtl/td4_datapath_reg.sv
// td4_datapath_reg: 74HC161-style register with async reset, enable, active-low load and optional count-up
module td4_datapath_reg #(
    parameter int WIDTH = 4,
    parameter bit COUNT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // load wins over count; a disabled step leaves the value untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= !load_n ? d : (COUNT ? q + WIDTH'(1) : q);
    end
endmodule

// File: rtl/td4_datapath.sv
// td4_datapath: TD4 execute stage with A/B/OUT/PC registers, source mux, adder and carry flag
module td4_datapath
    import td4_datapath_pkg::*;
#(
    parameter int WIDTH = TD4_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       load_n,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] in_port,
    output logic             carry_n,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b
);
    logic [WIDTH-1:0] src;
    logic [WIDTH:0]   total;
    logic             carry;

    // source mux feeding the adder; the carry-out rides in the top bit of total
    always_comb begin
        src   = select == SEL_A  ? reg_a :
                select == SEL_B  ? reg_b :
                select == SEL_IN ? in_port : '0;
        total = {1'b0, src} + {1'b0, imm};
    end

    // carry follows every executed instruction, whatever gets loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            carry <= 1'b0;
        else if (en)
            carry <= total[WIDTH];
    end

    assign carry_n = ~carry;

    td4_datapath_reg #(.WIDTH(WIDTH), .COUNT(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .load_n(load_n[LD_A]),
        .d(total[WIDTH-1:0]), .q(reg_a)
    );

    td4_datapath_reg #(.WIDTH(WIDTH), .COUNT(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .load_n(load_n[LD_B]),
        .d(total[WIDTH-1:0]), .q(reg_b)
    );

    td4_datapath_reg #(.WIDTH(WIDTH), .COUNT(1'b0)) u_out (
        .clk(clk), .rst_n(rst_n), .en(en), .load_n(load_n[LD_OUT]),
        .d(total[WIDTH-1:0]), .q(out_port)
    );

    td4_datapath_reg #(.WIDTH(WIDTH), .COUNT(1'b1)) u_pc (
        .clk(clk), .rst_n(rst_n), .en(en), .load_n(load_n[LD_PC]),
        .d(total[WIDTH-1:0]), .q(pc)
    );
endmodule

// File: doc/td4_datapath.md
Name: td4_datapath

Overview:
- Execute/register stage of the TD4 CPU, directly downstream of INST_DECODER.
- Consumes INST_DECODER's `load_n[3:0]` and `select[1:0]` plus the instruction immediate.
- Holds registers A, B, OUT and PC, the 4-bit source mux and adder, and the carry flag.
- Returns `carry_n` to INST_DECODER and `pc` to the instruction ROM.

Parameters:
- WIDTH, 4, width of A, B, OUT, PC, the input port and the adder. Fixed at 4 for TD4; parameterised only for the bench.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  step enable; 0 freezes all state (single-step / halt)
- load_n  input  4  active-low register loads from INST_DECODER: [0]=A, [1]=B, [2]=OUT, [3]=PC
- select  input  2  adder source from INST_DECODER: 0=A, 1=B, 2=in_port, 3=zero
- imm  input  WIDTH  immediate, inst[3:0]
- in_port  input  WIDTH  external input switches
- carry_n  output  1  inverted carry flag, to INST_DECODER
- pc  output  WIDTH  program counter, ROM address
- out_port  output  WIDTH  OUT register
- reg_a  output  WIDTH  A register (debug/bench visibility)
- reg_b  output  WIDTH  B register (debug/bench visibility)

Behaviour:
- Reset (rst_n=0, asynchronous, any time, including mid-step):
  - A=B=OUT=PC=0, carry=0, so carry_n=1.
  - Takes effect immediately, without waiting for clk.
- Combinational path:
  - src = mux(select): 0→A, 1→B, 2→in_port, 3→0.
  - {cout, sum} = src + imm, computed WIDTH+1 bits wide.
  - sum wraps modulo 2^WIDTH (e.g. F+1 → sum=0, cout=1).
- Rising edge of clk with en=1, single-cycle execution (one instruction per cycle):
  - A <= sum if load_n[0]=0, else hold.
  - B <= sum if load_n[1]=0, else hold.
  - OUT <= sum if load_n[2]=0, else hold.
  - PC <= sum if load_n[3]=0, else PC+1 (wraps F→0).
  - carry <= cout every enabled cycle, regardless of load_n. MOV/IN/OUT/JMP therefore update carry too; this is intended TD4 behaviour.
- Rising edge with en=0: every register, including carry, holds; outputs are stable.
- Multiple load_n bits low in the same cycle: each selected register loads the same sum. No priority logic. Illegal for a real decoder, but defined.
- load_n=4'b1111: no register write; PC increments; carry still updates.
- Latency:
  - Outputs are registered; new values are visible one clk after the instruction is presented.
  - carry_n presented during cycle n reflects the instruction executed in cycle n-1 (JNC semantics).
- X on load_n/select when en=0 must not corrupt state.

Decomposition:
- Shared include `td4_defs.vh`:
  - SEL_A=2'd0, SEL_B=2'd1, SEL_IN=2'd2, SEL_ZERO=2'd3.
  - LD_A=0, LD_B=1, LD_OUT=2, LD_PC=3 (bit indices into load_n).
  - WIDTH default.
- INST_DECODER and this block both include it.
- One natural sub-module: `td4_reg`, a WIDTH-bit register with async active-low reset, en, active-low load and optional count-up (74HC161 equivalent).
  - Instantiated four times: A, B and OUT with count disabled; PC with count enabled.

Test Plan:
- Reset: assert rst_n=0 between edges with A=5, PC=7 → A, B, OUT, PC=0 and carry_n=1 immediately, before the next clk.
- MOV A,Im then ADD A,Im: select=3, load_n=1110, imm=9, then select=0, load_n=1110, imm=8 → A=9, then A=1 with carry_n=0; PC=1, then 2.
- MOV B,A / OUT B / IN A: from A=3, select=0, load_n=1101, imm=0 → B=3; then select=1, load_n=1011 → out_port=3; then in_port=A(hex), select=2, load_n=1110 → A=A(hex), carry_n=1.
- JMP and PC wrap:
  - PC=F, load_n=1111 → PC=0.
  - select=3, load_n=0111, imm=C → PC=C; A, B and OUT unchanged.
- JNC loop: ADD A,1 repeatedly from A=E, with decoder-style gating on carry_n → carry_n=0 after A wraps to 0; the following JNC-taken/not-taken PC values match the model.
- Stall: en=0 for 3 cycles with load_n=0000 and X on select → all outputs unchanged; en=1 resumes with PC+1.
